// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: four per-producer {tag, data} FIFOs drained round-robin,
// at most one registered broadcast per clock.
module cdb_arbiter #(
   parameter int         DEPTH       = 2,
   parameter logic [5:0] INVALID_NUM = 6'b111111
) (
   input  logic         in_clock,
   input  logic         in_reset,
   input  logic [3:0]   in_req_valid,
   input  logic [23:0]  in_req_tag,
   input  logic [127:0] in_req_data,
   output logic [3:0]   out_ready,
   output logic         out_CDB_is_cast,
   output logic [5:0]   out_CDB_tag,
   output logic [31:0]  out_CDB_data,
   output logic [1:0]   out_CDB_src,
   output logic         out_overflow,
   output logic         out_bad_tag
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [3:0]  w_push;
   logic [3:0]  w_pop;
   logic [3:0]  w_nonempty;
   logic [3:0]  w_ovf;
   logic [3:0]  w_bad;
   logic [5:0]  w_head_tag  [4];
   logic [31:0] w_head_data [4];
   logic        w_grant;
   logic [1:0]  w_sel;
   logic [1:0]  w_cand;

   logic [1:0]  r_last;
   logic        r_cast;
   logic [5:0]  r_tag;
   logic [31:0] r_data;
   logic [1:0]  r_src;
   logic        r_overflow;
   logic        r_bad_tag;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_fifo
         logic [5:0]    r_mem_tag  [DEPTH];
         logic [31:0]   r_mem_data [DEPTH];
         logic [PW-1:0] r_wptr;
         logic [PW-1:0] r_rptr;
         logic [CW-1:0] r_count;
         logic [5:0]    w_tag;
         logic [31:0]   w_data;

         assign w_tag              = in_req_tag[6*gi +: 6];
         assign w_data             = in_req_data[32*gi +: 32];
         assign out_ready[gi]      = (r_count != CW'(DEPTH));
         assign w_nonempty[gi]     = (r_count != '0);
         assign w_bad[gi]          = in_req_valid[gi] && (w_tag == INVALID_NUM);
         assign w_ovf[gi]          = in_req_valid[gi] && !out_ready[gi];
         assign w_push[gi]         = in_req_valid[gi] && out_ready[gi] && (w_tag != INVALID_NUM);
         assign w_pop[gi]          = w_grant && (w_sel == 2'(gi));
         assign w_head_tag[gi]     = r_mem_tag[r_rptr];
         assign w_head_data[gi]    = r_mem_data[r_rptr];

         always_ff @(posedge in_clock) begin
            if (w_push[gi]) begin
               r_mem_tag[r_wptr]  <= w_tag;
               r_mem_data[r_wptr] <= w_data;
            end
         end

         // Pointers wrap naturally since DEPTH is a power of two.
         always_ff @(posedge in_clock) begin
            if (in_reset) begin
               r_wptr  <= '0;
               r_rptr  <= '0;
               r_count <= '0;
            end else begin
               if (w_push[gi]) r_wptr <= r_wptr + PW'(1);
               if (w_pop[gi])  r_rptr <= r_rptr + PW'(1);
               case ({w_push[gi], w_pop[gi]})
                  2'b10:   r_count <= r_count + CW'(1);
                  2'b01:   r_count <= r_count - CW'(1);
                  default: r_count <= r_count;
               endcase
            end
         end
      end
   endgenerate

   // Search last+1 .. last+4 (= last); the first non-empty FIFO wins.
   always_comb begin
      w_grant = 1'b0;
      w_sel   = r_last;
      w_cand  = r_last;
      for (int i = 1; i <= 4; i++) begin
         w_cand = r_last + 2'(i);
         if (!w_grant && w_nonempty[w_cand]) begin
            w_grant = 1'b1;
            w_sel   = w_cand;
         end
      end
   end

   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         r_last     <= 2'd3;
         r_cast     <= 1'b0;
         r_tag      <= INVALID_NUM;
         r_data     <= '0;
         r_src      <= '0;
         r_overflow <= 1'b0;
         r_bad_tag  <= 1'b0;
      end else begin
         r_cast <= w_grant;
         if (w_grant) begin
            r_tag  <= w_head_tag[w_sel];
            r_data <= w_head_data[w_sel];
            r_src  <= w_sel;
            r_last <= w_sel;
         end
         if (|w_ovf) r_overflow <= 1'b1;
         if (|w_bad) r_bad_tag  <= 1'b1;
      end
   end

   assign out_CDB_is_cast = r_cast;
   assign out_CDB_tag     = r_tag;
   assign out_CDB_data    = r_data;
   assign out_CDB_src     = r_src;
   assign out_overflow    = r_overflow;
   assign out_bad_tag     = r_bad_tag;

endmodule
